// File: rtl/uart_imem_loader_pkg.sv
// Shared constants and state encoding for the UART instruction-memory loader.
//   CMD_*      : command bytes accepted from the UART RX FIFO
//   RSP_*      : status bytes returned through the UART TX FIFO
//   WSIZE_WORD : memory write-size code for a full 32-bit word
//   loader_state_t : loader FSM states
package uart_loader_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'
  localparam logic [7:0] CMD_STOP = 8'h53;  // 'S'

  localparam logic [7:0] RSP_OK   = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR  = 8'h45;  // 'E'

  localparam logic [1:0] WSIZE_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_DEC,
    ST_CNT,
    ST_DATA,
    ST_WRITE,
    ST_RESP
  } loader_state_t;

endpackage

// File: rtl/uart_imem_loader_if.sv
// Bus bundle between the loader, the UART0 RX/TX FIFOs and instruction memory.
//   RX : i_rx_data, i_rx_empty (FIFO -> loader), o_rx_ren (loader -> FIFO)
//   TX : i_tx_full (FIFO -> loader), o_tx_wdata, o_tx_wen (loader -> FIFO)
//   IMEM : o_imem_data, o_imem_waddr, o_imem_wen, o_mem_wsize (loader -> memory)
// master = the loader, slave = the FIFOs/memory side.
interface uart_imem_loader_if #(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int NB_UART_DATA    = 9
);
  logic [NB_UART_DATA-1:0]    i_rx_data;
  logic                       i_rx_empty;
  logic                       o_rx_ren;
  logic                       i_tx_full;
  logic [NB_UART_DATA-1:0]    o_tx_wdata;
  logic                       o_tx_wen;
  logic [NB_INSTRUCTION-1:0]  o_imem_data;
  logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr;
  logic                       o_imem_wen;
  logic [1:0]                 o_mem_wsize;

  modport master (
    input  i_rx_data, i_rx_empty, i_tx_full,
    output o_rx_ren, o_tx_wdata, o_tx_wen,
           o_imem_data, o_imem_waddr, o_imem_wen, o_mem_wsize
  );

  modport slave (
    output i_rx_data, i_rx_empty, i_tx_full,
    input  o_rx_ren, o_tx_wdata, o_tx_wen,
           o_imem_data, o_imem_waddr, o_imem_wen, o_mem_wsize
  );
endinterface

// File: rtl/uart_imem_loader_byte_packer.sv
// byte_packer: assembles little-endian bytes into an instruction word.
//   clk, i_rst     : clock, async active-low reset
//   i_clear        : synchronous clear of word and byte index
//   i_shift        : accept i_byte this cycle
//   i_byte         : incoming byte (first byte of a word lands in [7:0])
//   o_word         : assembled word
//   o_word_done    : high in the cycle the last byte of a word is shifted in
module byte_packer #(
  parameter int NB_INSTRUCTION = 32
) (
  input  logic                      clk,
  input  logic                      i_rst,
  input  logic                      i_clear,
  input  logic                      i_shift,
  input  logic [7:0]                i_byte,
  output logic [NB_INSTRUCTION-1:0] o_word,
  output logic                      o_word_done
);
  localparam int NB_BYTES = NB_INSTRUCTION / 8;
  localparam int IDX_W    = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_BYTES - 1);

  logic [IDX_W-1:0] byte_idx;

  assign o_word_done = i_shift && (byte_idx == LAST_IDX);

  // Bytes enter at the top and move down, so after NB_BYTES shifts the
  // first byte received sits in [7:0].
  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      o_word   <= '0;
      byte_idx <= '0;
    end else if (i_clear) begin
      o_word   <= '0;
      byte_idx <= '0;
    end else if (i_shift) begin
      o_word   <= {i_byte, o_word[NB_INSTRUCTION-1:8]};
      byte_idx <= (byte_idx == LAST_IDX) ? '0 : byte_idx + 1'b1;
    end
  end
endmodule

// File: rtl/uart_imem_loader.sv
// uart_imem_loader: command-driven program loader between UART0 and the CPU.
//   clk, i_rst : clock, async active-low reset
//   bus        : RX/TX FIFO handshake and instruction-memory write port
//   o_cpu_en   : CPU run enable ('R' sets, 'S' and 'L' clear)
//   o_busy     : high whenever the loader is not idle
// Commands: 'L' N <4*N bytes> loads N words from address 0; 'R'/'S' run/stop.
// Every command is answered with one status byte ('K' or 'E').
module uart_imem_loader
  import uart_loader_pkg::*;
#(
  parameter int NB_INSTRUCTION  = 32,
  parameter int IMEM_ADDR_WIDTH = 8,
  parameter int NB_UART_DATA    = 9
) (
  input  logic               clk,
  input  logic               i_rst,
  uart_imem_loader_if.master bus,
  output logic               o_cpu_en,
  output logic               o_busy
);
  localparam int WCNT_W    = IMEM_ADDR_WIDTH - 1;
  localparam int MAX_WORDS = 2 ** (IMEM_ADDR_WIDTH - 2);

  loader_state_t              state, state_nx;
  logic [7:0]                 cmd_byte;
  logic [7:0]                 rsp_byte;
  logic [WCNT_W-1:0]          words_left;
  logic [IMEM_ADDR_WIDTH-1:0] waddr;
  logic                       cpu_en;

  logic       rx_ren;
  logic       tx_wen;
  logic       imem_wen;
  logic       pk_clear;
  logic       pk_shift;
  logic       pk_word_done;
  logic       count_ok;
  logic [7:0] rx_byte;
  logic [NB_INSTRUCTION-1:0] pk_word;
  logic       unused_rx_hi;

  assign rx_byte      = bus.i_rx_data[7:0];
  assign unused_rx_hi = ^bus.i_rx_data[NB_UART_DATA-1:8];
  assign count_ok     = (rx_byte != 8'd0) && (32'(rx_byte) <= 32'(MAX_WORDS));

  byte_packer #(
    .NB_INSTRUCTION(NB_INSTRUCTION)
  ) u_packer (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_clear     (pk_clear),
    .i_shift     (pk_shift),
    .i_byte      (rx_byte),
    .o_word      (pk_word),
    .o_word_done (pk_word_done)
  );

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rx_ren   = 1'b0;
    tx_wen   = 1'b0;
    imem_wen = 1'b0;
    pk_clear = 1'b0;
    pk_shift = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!bus.i_rx_empty) begin
          rx_ren   = 1'b1;
          state_nx = ST_CMD_DEC;
        end
      end
      ST_CMD_DEC: state_nx = (cmd_byte == CMD_LOAD) ? ST_CNT : ST_RESP;
      ST_CNT: begin
        if (!bus.i_rx_empty) begin
          rx_ren   = 1'b1;
          pk_clear = 1'b1;
          state_nx = count_ok ? ST_DATA : ST_RESP;
        end
      end
      ST_DATA: begin
        if (!bus.i_rx_empty) begin
          rx_ren   = 1'b1;
          pk_shift = 1'b1;
          if (pk_word_done) state_nx = ST_WRITE;
        end
      end
      ST_WRITE: begin
        imem_wen = 1'b1;
        state_nx = (words_left == WCNT_W'(1)) ? ST_RESP : ST_DATA;
      end
      ST_RESP: begin
        if (!bus.i_tx_full) begin
          tx_wen   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      cmd_byte   <= '0;
      rsp_byte   <= '0;
      words_left <= '0;
      waddr      <= '0;
      cpu_en     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (rx_ren) begin
            cmd_byte <= rx_byte;
            // Halt the CPU on the very edge that consumes the load command.
            if (rx_byte == CMD_LOAD) cpu_en <= 1'b0;
          end
        end
        ST_CMD_DEC: begin
          case (cmd_byte)
            CMD_RUN:  begin cpu_en <= 1'b1; rsp_byte <= RSP_OK; end
            CMD_STOP: begin cpu_en <= 1'b0; rsp_byte <= RSP_OK; end
            CMD_LOAD: ;
            default:  rsp_byte <= RSP_ERR;
          endcase
        end
        ST_CNT: begin
          if (rx_ren) begin
            if (count_ok) begin
              words_left <= WCNT_W'(rx_byte);
              waddr      <= '0;
            end else begin
              rsp_byte <= RSP_ERR;
            end
          end
        end
        ST_WRITE: begin
          waddr      <= waddr + IMEM_ADDR_WIDTH'(4);
          words_left <= words_left - 1'b1;
          if (words_left == WCNT_W'(1)) rsp_byte <= RSP_OK;
        end
        default: ;
      endcase
    end
  end

  // The pop strobe is gated by reset so that it stays low while reset is
  // held even though IDLE would otherwise pop a waiting byte.
  assign bus.o_rx_ren     = rx_ren && i_rst;
  assign bus.o_tx_wen     = tx_wen;
  assign bus.o_tx_wdata   = NB_UART_DATA'(rsp_byte);
  assign bus.o_imem_wen   = imem_wen;
  assign bus.o_imem_data  = pk_word;
  assign bus.o_imem_waddr = waddr;
  assign bus.o_mem_wsize  = WSIZE_WORD;
  assign o_cpu_en         = cpu_en;
  assign o_busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: RX/TX FIFO and memory models,
// a command-level reference model, table vectors and randomized commands.
module tb_uart_imem_loader;
  import uart_loader_pkg::*;

  logic clk = 1'b0;
  logic i_rst;
  logic cpu_en, busy;

  always #5 clk = ~clk;

  uart_imem_loader_if #(.NB_INSTRUCTION(32), .IMEM_ADDR_WIDTH(8), .NB_UART_DATA(9)) bus ();

  uart_imem_loader #(
    .NB_INSTRUCTION (32),
    .IMEM_ADDR_WIDTH(8),
    .NB_UART_DATA   (9)
  ) dut (
    .clk      (clk),
    .i_rst    (i_rst),
    .bus      (bus),
    .o_cpu_en (cpu_en),
    .o_busy   (busy)
  );

  typedef struct { logic [7:0] addr; logic [31:0] data; int cyc; } wr_t;
  typedef struct { logic [7:0] addr; logic [31:0] data; } ewr_t;
  typedef struct { logic [7:0] cmd; logic [7:0] rsp; logic cpu; } vec_t;

  logic [7:0] rx_q[$];
  logic [7:0] tx_log[$];
  logic [7:0] exp_tx[$];
  wr_t        wr_log[$];
  ewr_t       exp_wr[$];
  logic       exp_cpu;

  int  cyc = 0;
  int  pop_cyc, tx_cyc, cpu_chg_cyc;
  bit  pop_pending = 0;
  bit  cpu_prev = 0;
  bit  cpu_seen_high;
  int  overlap_errs = 0, align_errs = 0, wsize_errs = 0, tx_hi_errs = 0;
  int  gap_pct = 0;
  bit  full_force = 0, full_rand = 0;
  int  checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name, input int waited);
    checks++;
    failures++;
    $display("FAIL %s: waited %0d cycles, required completion before that", name, waited);
  endtask

  // FIFO/status driver: applies pops seen at the previous negedge, then
  // presents the next head (with optional gaps) and the TX full flag.
  initial begin
    bus.i_rx_empty = 1'b1;
    bus.i_rx_data  = '0;
    bus.i_tx_full  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (pop_pending && rx_q.size() != 0) void'(rx_q.pop_front());
      pop_pending = 0;
      if (rx_q.size() != 0 && !(gap_pct != 0 && $urandom_range(0, 99) < gap_pct)) begin
        bus.i_rx_empty = 1'b0;
        bus.i_rx_data  = {1'($urandom_range(0, 1)), rx_q[0]};
      end else begin
        bus.i_rx_empty = 1'b1;
        bus.i_rx_data  = '0;
      end
      bus.i_tx_full = full_force || (full_rand && ($urandom_range(0, 2) == 0));
    end
  end

  // Monitor: sampled on the falling edge, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_rx_ren) begin pop_pending = 1; pop_cyc = cyc; end
      if (bus.o_tx_wen) begin
        tx_log.push_back(bus.o_tx_wdata[7:0]);
        tx_cyc = cyc;
        if (bus.o_tx_wdata[8] !== 1'b0) tx_hi_errs++;
      end
      if (bus.o_rx_ren && bus.o_tx_wen) overlap_errs++;
      if (bus.o_imem_wen) begin
        wr_log.push_back('{addr: bus.o_imem_waddr, data: bus.o_imem_data, cyc: cyc});
        if (bus.o_imem_waddr[1:0] != 2'b00) align_errs++;
      end
      if (bus.o_mem_wsize !== 2'b10) wsize_errs++;
      if (cpu_en !== cpu_prev) cpu_chg_cyc = cyc;
      cpu_prev = cpu_en;
      if (cpu_en) cpu_seen_high = 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, required run to end earlier");
    $fatal(1, "watchdog");
  end

  // Reference model: command-level behaviour.
  task automatic send_cmd(input logic [7:0] b);
    rx_q.push_back(b);
    if (b == 8'h52) begin exp_tx.push_back(8'h4B); exp_cpu = 1'b1; end
    else if (b == 8'h53) begin exp_tx.push_back(8'h4B); exp_cpu = 1'b0; end
    else exp_tx.push_back(8'h45);
  endtask

  task automatic send_load(input int n, input logic [31:0] words[$]);
    rx_q.push_back(8'h4C);
    rx_q.push_back(8'(n));
    exp_cpu = 1'b0;
    if (n >= 1 && n <= 64) begin
      for (int i = 0; i < n; i++) begin
        for (int b = 0; b < 4; b++) rx_q.push_back(words[i][8*b +: 8]);
        exp_wr.push_back('{addr: 8'(4 * i), data: words[i]});
      end
      exp_tx.push_back(8'h4B);
    end else begin
      exp_tx.push_back(8'h45);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while ((rx_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n >= budget) timeout_fail("idle_wait", n);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_tx_count"}, tx_log.size(), exp_tx.size());
    for (int i = 0; i < tx_log.size() && i < exp_tx.size(); i++)
      chk({tag, "_tx_byte"}, tx_log[i], exp_tx[i]);
    chk({tag, "_wr_count"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
      chk({tag, "_wr_addr"}, wr_log[i].addr, exp_wr[i].addr);
      chk({tag, "_wr_data"}, wr_log[i].data, exp_wr[i].data);
    end
    chk({tag, "_cpu_en"}, cpu_en, exp_cpu);
    tx_log.delete(); exp_tx.delete(); wr_log.delete(); exp_wr.delete();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rx_ren"}, bus.o_rx_ren, 0);
    chk({tag, "_tx_wen"}, bus.o_tx_wen, 0);
    chk({tag, "_tx_wdata"}, bus.o_tx_wdata, 0);
    chk({tag, "_imem_wen"}, bus.o_imem_wen, 0);
    chk({tag, "_imem_data"}, bus.o_imem_data, 0);
    chk({tag, "_imem_waddr"}, bus.o_imem_waddr, 0);
    chk({tag, "_cpu_en"}, cpu_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wsize"}, bus.o_mem_wsize, 2'b10);
  endtask

  vec_t vt[8];

  initial begin
    logic [31:0] words[$];
    logic [7:0]  pb[6];
    int          n;

    exp_cpu = 1'b0;
    i_rst = 1'b1;
    #3 i_rst = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1 i_rst = 1'b1;

    // Run/stop latency: command popped at t, cpu_en and TX push at t+2.
    send_cmd(8'h52);
    wait_idle(100);
    chk("run_tx_latency", tx_cyc - pop_cyc, 2);
    chk("run_cpu_latency", cpu_chg_cyc - pop_cyc, 2);
    check_results("run");
    send_cmd(8'h53);
    wait_idle(100);
    chk("stop_tx_latency", tx_cyc - pop_cyc, 2);
    chk("stop_cpu_latency", cpu_chg_cyc - pop_cyc, 2);
    check_results("stop");

    // Single-byte command table.
    vt[0] = '{8'h52, 8'h4B, 1'b1};
    vt[1] = '{8'h7A, 8'h45, 1'b1};
    vt[2] = '{8'h53, 8'h4B, 1'b0};
    vt[3] = '{8'h00, 8'h45, 1'b0};
    vt[4] = '{8'hFF, 8'h45, 1'b0};
    vt[5] = '{8'h52, 8'h4B, 1'b1};
    vt[6] = '{8'h4B, 8'h45, 1'b1};
    vt[7] = '{8'h6C, 8'h45, 1'b1};
    for (int i = 0; i < 8; i++) begin
      rx_q.push_back(vt[i].cmd);
      wait_idle(100);
      chk("vec_tx_count", tx_log.size(), 1);
      if (tx_log.size() != 0) chk("vec_rsp", tx_log[0], vt[i].rsp);
      chk("vec_cpu_en", cpu_en, vt[i].cpu);
      tx_log.delete();
    end
    exp_cpu = 1'b1;

    // Two-word load from a halted CPU, back-to-back bytes.
    send_cmd(8'h53);
    wait_idle(100);
    check_results("pre_load");
    cpu_seen_high = 0;
    foreach (pb[i]) pb[i] = 8'h00;
    rx_q.push_back(8'h4C); rx_q.push_back(8'h02);
    rx_q.push_back(8'h13); rx_q.push_back(8'h05); rx_q.push_back(8'h00); rx_q.push_back(8'h00);
    rx_q.push_back(8'h93); rx_q.push_back(8'h05); rx_q.push_back(8'h10); rx_q.push_back(8'h00);
    exp_wr.push_back('{addr: 8'h00, data: 32'h0000_0513});
    exp_wr.push_back('{addr: 8'h04, data: 32'h0010_0593});
    exp_tx.push_back(8'h4B);
    exp_cpu = 1'b0;
    wait_idle(200);
    chk("load2_cpu_never_high", cpu_seen_high, 0);
    if (wr_log.size() == 2) begin
      chk("load2_word_period", wr_log[1].cyc - wr_log[0].cyc, 5);
      chk("load2_k_after_write", tx_cyc > wr_log[1].cyc, 1);
    end
    check_results("load2");

    // Invalid counts: zero and one past capacity; CPU was running first.
    send_cmd(8'h52); wait_idle(100); check_results("pre_bad");
    words.delete();
    send_load(0, words);  wait_idle(100); check_results("load_n0");
    send_load(65, words); wait_idle(100); check_results("load_n65");
    send_cmd(8'h7A);      wait_idle(100); check_results("other_cmd");

    // Full-capacity load with RX gaps; TX full holds back the final 'K'.
    words.delete();
    for (int i = 0; i < 64; i++) words.push_back($urandom);
    gap_pct = 30;
    full_force = 1;
    send_load(64, words);
    n = 0;
    while (wr_log.size() < 64 && n < 6000) begin @(negedge clk); n++; end
    if (n >= 6000) timeout_fail("load64_writes", n);
    repeat (10) @(negedge clk);
    chk("load64_k_held", tx_log.size(), 0);
    chk("load64_busy_held", busy, 1);
    full_force = 0;
    wait_idle(100);
    gap_pct = 0;
    check_results("load64");

    // Reset in the middle of the second word of a load.
    send_cmd(8'h52); wait_idle(100); check_results("pre_rst");
    foreach (pb[i]) pb[i] = 8'($urandom);
    rx_q.push_back(8'h4C); rx_q.push_back(8'h02);
    foreach (pb[i]) rx_q.push_back(pb[i]);
    n = 0;
    while (rx_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) timeout_fail("rst_partial_feed", n);
    repeat (3) @(negedge clk);
    chk("rst_partial_wr_count", wr_log.size(), 1);
    if (wr_log.size() != 0) begin
      chk("rst_partial_wr_addr", wr_log[0].addr, 8'h00);
      chk("rst_partial_wr_data", wr_log[0].data, {pb[3], pb[2], pb[1], pb[0]});
    end
    chk("rst_partial_busy", busy, 1);
    @(posedge clk); #1 i_rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_reset");
    @(posedge clk); #1 i_rst = 1'b1;
    tx_log.delete(); wr_log.delete(); exp_tx.delete(); exp_wr.delete();
    exp_cpu = 1'b0;
    words.delete();
    words.push_back($urandom);
    send_load(1, words);
    wait_idle(100);
    check_results("post_rst_load");

    // Randomized command stream with RX gaps and random TX back-pressure.
    gap_pct = 20;
    full_rand = 1;
    for (int k = 0; k < 40; k++) begin
      int sel = $urandom_range(0, 9);
      if (sel <= 2) begin
        send_cmd(($urandom_range(0, 1) == 0) ? 8'h52 : 8'h53);
      end else if (sel <= 4) begin
        logic [7:0] b;
        do b = 8'($urandom); while (b == 8'h4C || b == 8'h52 || b == 8'h53);
        send_cmd(b);
      end else begin
        int nw;
        if ($urandom_range(0, 4) == 0) nw = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(65, 255);
        else nw = $urandom_range(1, 6);
        words.delete();
        for (int i = 0; i < nw && i < 64; i++) words.push_back($urandom);
        send_load(nw, words);
      end
      wait_idle(2000);
      check_results("rand");
    end
    full_rand = 0;
    gap_pct = 0;

    chk("rx_tx_same_cycle", overlap_errs, 0);
    chk("waddr_alignment", align_errs, 0);
    chk("wsize_constant", wsize_errs, 0);
    chk("tx_upper_bits", tx_hi_errs, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
